// File: rtl/fetch_controller_if.sv
// Bundle of control, loader and fetch-datapath signals around the fetch controller.
// The controller takes the slave view; the core, loader and fetch datapath take the master view.
interface fetch_controller_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              halt_req;
    logic              stall;
    logic              branch_req;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] branchPC;
    logic              ldPC;
    logic              ldNPC;
    logic              ldInst;
    logic              clrPC;
    logic              clrNPC;
    logic              clrInst;
    logic              isBranchTaken;
    logic              load_req;
    logic              load_gnt;
    logic              load_valid;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              wr;
    logic [ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0] writeData;
    logic              inst_valid;
    logic              running;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        output start, halt_req, stall, branch_req, branch_target,
        output load_req, load_valid, load_addr, load_data,
        input  branchPC, ldPC, ldNPC, ldInst, clrPC, clrNPC, clrInst, isBranchTaken,
        input  load_gnt, wr, writeAddr, writeData, inst_valid, running, fetch_count
    );

    modport slave (
        input  start, halt_req, stall, branch_req, branch_target,
        input  load_req, load_valid, load_addr, load_data,
        output branchPC, ldPC, ldNPC, ldInst, clrPC, clrNPC, clrInst, isBranchTaken,
        output load_gnt, wr, writeAddr, writeData, inst_valid, running, fetch_count
    );
endinterface

// File: rtl/fetch_controller.sv
// Two-cycle fetch sequencer (CLEAR, then FETCH/UPDATE pairs) that also hands the
// instruction-memory write port to the program loader whenever fetch is stopped.
module fetch_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    fetch_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_FETCH, S_UPDATE, S_HALT
    } state_t;

    state_t            r_state, w_next;
    logic              r_br_pend, r_halt, r_inst_valid;
    logic [ADDR_W-1:0] r_branch_pc;
    logic [CNT_W-1:0]  r_count;

    logic              w_run;
    logic              w_ldPC, w_ldNPC, w_ldInst, w_clrPC, w_clrNPC, w_clrInst, w_isbt;
    logic              w_gnt, w_wr;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_run = (r_state == S_CLEAR) || (r_state == S_FETCH) || (r_state == S_UPDATE);

    always_comb begin
        w_next   = r_state;
        w_ldPC   = 1'b0;
        w_ldNPC  = 1'b0;
        w_ldInst = 1'b0;
        w_clrPC  = 1'b0;
        w_clrNPC = 1'b0;
        w_clrInst = 1'b0;
        w_isbt   = 1'b0;
        w_gnt    = 1'b0;
        w_wr     = 1'b0;
        w_waddr  = '0;
        w_wdata  = '0;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (bus.load_req)   w_next = S_LOAD;
                else if (bus.start) w_next = S_CLEAR;
            end
            S_LOAD: begin
                w_gnt   = 1'b1;
                w_wr    = bus.load_valid;
                w_waddr = bus.load_addr;
                w_wdata = bus.load_data;
                if (!bus.load_req) w_next = S_IDLE;
            end
            S_CLEAR: begin
                // NPC only clears on a load edge, so ldNPC accompanies clrNPC.
                w_clrPC   = 1'b1;
                w_clrInst = 1'b1;
                w_clrNPC  = 1'b1;
                w_ldNPC   = 1'b1;
                w_next    = S_FETCH;
            end
            S_FETCH: begin
                if (!bus.stall) begin
                    w_ldInst = 1'b1;
                    w_ldNPC  = 1'b1;
                    w_next   = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (!bus.stall) begin
                    w_ldPC = 1'b1;
                    if (r_br_pend) begin
                        w_isbt    = 1'b1;
                        w_clrInst = 1'b1;
                    end
                    w_next = (r_halt || bus.halt_req) ? S_HALT : S_FETCH;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_br_pend    <= 1'b0;
            r_halt       <= 1'b0;
            r_inst_valid <= 1'b0;
            r_branch_pc  <= '0;
            r_count      <= '0;
        end else begin
            r_state <= w_next;
            // A new branch in the consuming UPDATE re-arms pending with the new target.
            if (w_run && bus.branch_req) begin
                r_branch_pc <= bus.branch_target;
                r_br_pend   <= 1'b1;
            end else if (r_state == S_CLEAR || w_isbt) begin
                r_br_pend   <= 1'b0;
            end
            if (w_run && bus.halt_req)  r_halt <= 1'b1;
            else if (r_state == S_CLEAR) r_halt <= 1'b0;
            if (r_state == S_CLEAR) r_count <= '0;
            else if (w_ldInst)      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_clrInst)          r_inst_valid <= 1'b0;
            else if (w_ldInst)      r_inst_valid <= 1'b1;
        end
    end

    assign bus.branchPC      = r_branch_pc;
    assign bus.ldPC          = w_ldPC;
    assign bus.ldNPC         = w_ldNPC;
    assign bus.ldInst        = w_ldInst;
    assign bus.clrPC         = w_clrPC;
    assign bus.clrNPC        = w_clrNPC;
    assign bus.clrInst       = w_clrInst;
    assign bus.isBranchTaken = w_isbt;
    assign bus.load_gnt      = w_gnt;
    assign bus.wr            = w_wr;
    assign bus.writeAddr     = w_waddr;
    assign bus.writeData     = w_wdata;
    assign bus.inst_valid    = r_inst_valid;
    assign bus.running       = w_run;
    assign bus.fetch_count   = r_count;
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a small fetch-datapath and instruction-memory model.
module tb_fetch_controller;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_controller_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) bus ();

    fetch_controller #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fetch datapath model driven by the controller strobes.
    logic [31:0] mem [0:63];
    logic        mem_ready;
    logic [31:0] pc_m, npc_m, ir_m;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 + i;
            mem_ready <= 1'b1;
        end else if (bus.wr) begin
            mem[bus.writeAddr[7:2]] <= bus.writeData;
        end
        if (bus.clrPC)     pc_m <= 32'h0;
        else if (bus.ldPC) pc_m <= bus.isBranchTaken ? bus.branchPC : npc_m;
        if (bus.ldNPC)     npc_m <= bus.clrNPC ? 32'h0 : pc_m + 32'd4;
        if (bus.clrInst)     ir_m <= 32'h0;
        else if (bus.ldInst) ir_m <= mem[pc_m[7:2]];
    end

    logic [6:0] strb;
    assign strb = {bus.ldPC, bus.ldNPC, bus.ldInst, bus.clrPC, bus.clrNPC, bus.clrInst, bus.isBranchTaken};

    localparam logic [6:0] ST_NONE  = 7'b0000000;
    localparam logic [6:0] ST_CLEAR = 7'b0101110;
    localparam logic [6:0] ST_FETCH = 7'b0110000;
    localparam logic [6:0] ST_UPD   = 7'b1000000;
    localparam logic [6:0] ST_BR    = 7'b1000011;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mem_ready = 1'b0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.halt_req = 1'b0;
        bus.stall = 1'b0;
        bus.branch_req = 1'b0;
        bus.branch_target = 32'h0;
        bus.load_req = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_addr = 32'h0;
        bus.load_data = 32'h0;
        tick; tick; tick;

        chk("rst_strobes", strb, ST_NONE);
        chk("rst_running", bus.running, 0);
        chk("rst_gnt", bus.load_gnt, 0);
        chk("rst_wr", bus.wr, 0);
        chk("rst_count", bus.fetch_count, 0);
        chk("rst_branchPC", bus.branchPC, 0);
        chk("rst_inst_valid", bus.inst_valid, 0);

        // Basic start and steady-state fetch
        reset = 1'b1;
        tick;
        chk("idle_running", bus.running, 0);
        bus.start = 1'b1;
        tick;
        chk("t1_clear_strobes", strb, ST_CLEAR);
        chk("t1_clear_running", bus.running, 1);
        bus.start = 1'b0;
        tick;
        for (int k = 0; k < 3; k++) begin
            chk("t1_fetch_strobes", strb, ST_FETCH);
            chk("t1_fetch_pc", pc_m, 32'(4 * k));
            tick;
            chk("t1_upd_strobes", strb, ST_UPD);
            chk("t1_upd_count", bus.fetch_count, 32'(k + 1));
            chk("t1_upd_ir", ir_m, 32'hC0DE_0000 + 32'(k));
            chk("t1_upd_inst_valid", bus.inst_valid, 1);
            tick;
        end
        chk("t1_pc_12", pc_m, 32'd12);

        // Loader request while running, then reset in UPDATE
        bus.load_req = 1'b1;
        #1;
        chk("t6_gnt_running_fetch", bus.load_gnt, 0);
        chk("t6_running", bus.running, 1);
        tick;
        bus.load_valid = 1'b1;
        #1;
        chk("t6_gnt_running_upd", bus.load_gnt, 0);
        chk("t6_wr_running", bus.wr, 0);
        reset = 1'b0;
        #1;
        chk("t6_async_strobes", strb, ST_NONE);
        chk("t6_async_running", bus.running, 0);
        chk("t6_async_count", bus.fetch_count, 0);
        chk("t6_async_inst_valid", bus.inst_valid, 0);
        bus.load_valid = 1'b0;
        tick;
        chk("t6_in_reset_gnt", bus.load_gnt, 0);
        reset = 1'b1;
        tick;

        // Program load
        chk("t2_gnt", bus.load_gnt, 1);
        bus.start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_addr = 32'h0;
        bus.load_data = 32'h1111_1111;
        #1;
        chk("t2_wr0", bus.wr, 1);
        chk("t2_waddr0", bus.writeAddr, 32'h0);
        chk("t2_wdata0", bus.writeData, 32'h1111_1111);
        tick;
        bus.start = 1'b0;
        chk("t2_start_ignored_gnt", bus.load_gnt, 1);
        chk("t2_start_ignored_run", bus.running, 0);
        bus.load_addr = 32'h4;
        bus.load_data = 32'h2222_2222;
        #1;
        chk("t2_waddr1", bus.writeAddr, 32'h4);
        tick;
        bus.load_valid = 1'b0;
        bus.load_req = 1'b0;
        #1;
        chk("t2_wr_idle_valid", bus.wr, 0);
        tick;
        chk("t2_gnt_released", bus.load_gnt, 0);
        bus.load_valid = 1'b1;
        #1;
        chk("t2_wr_without_gnt", bus.wr, 0);
        bus.load_valid = 1'b0;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("t2_clear_strobes", strb, ST_CLEAR);
        tick;
        chk("t2_fetch_strobes", strb, ST_FETCH);
        tick;
        chk("t2_ir0", ir_m, 32'h1111_1111);
        tick;
        tick;
        chk("t2_ir1", ir_m, 32'h2222_2222);
        tick;

        // Branch resolved during FETCH at PC=8
        chk("t3_pc8", pc_m, 32'd8);
        bus.branch_req = 1'b1;
        bus.branch_target = 32'h40;
        tick;
        bus.branch_req = 1'b0;
        chk("t3_upd_branch_strobes", strb, ST_BR);
        chk("t3_branchPC", bus.branchPC, 32'h40);
        tick;
        chk("t3_pc_target", pc_m, 32'h40);
        chk("t3_squash_valid", bus.inst_valid, 0);
        chk("t3_count", bus.fetch_count, 3);
        tick;
        chk("t3_upd_plain", strb, ST_UPD);
        chk("t3_ir_target", ir_m, 32'hC0DE_0010);
        chk("t3_count_after", bus.fetch_count, 4);
        tick;

        // Stall three cycles in FETCH
        bus.stall = 1'b1;
        #1;
        chk("t4_stall_strobes0", strb, ST_NONE);
        tick;
        chk("t4_stall_strobes1", strb, ST_NONE);
        tick;
        chk("t4_stall_strobes2", strb, ST_NONE);
        tick;
        chk("t4_stall_pc", pc_m, 32'h44);
        chk("t4_stall_count", bus.fetch_count, 4);
        bus.stall = 1'b0;
        #1;
        chk("t4_resume_strobes", strb, ST_FETCH);
        tick;
        chk("t4_resume_count", bus.fetch_count, 5);
        chk("t4_resume_ir", ir_m, 32'hC0DE_0011);
        tick;

        // Halt together with a pending branch
        chk("t5_pc48", pc_m, 32'h48);
        bus.branch_req = 1'b1;
        bus.branch_target = 32'h80;
        bus.halt_req = 1'b1;
        tick;
        bus.branch_req = 1'b0;
        bus.halt_req = 1'b0;
        chk("t5_final_upd", strb, ST_BR);
        chk("t5_final_run", bus.running, 1);
        tick;
        chk("t5_halt_running", bus.running, 0);
        chk("t5_halt_strobes", strb, ST_NONE);
        chk("t5_halt_pc", pc_m, 32'h80);
        chk("t5_halt_count", bus.fetch_count, 6);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("t5_restart_clear", strb, ST_CLEAR);
        tick;
        chk("t5_restart_pc", pc_m, 32'h0);
        chk("t5_restart_count", bus.fetch_count, 0);
        tick;
        chk("t5_restart_upd", strb, ST_UPD);
        chk("t5_restart_count1", bus.fetch_count, 1);
        chk("t5_restart_ir", ir_m, 32'h1111_1111);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
